// File: rtl/rv_control_unit.sv
// Decode-stage control unit: maps opcode/func3/func7/immediate to ALU op and
// write-back controls, registered once to form the decode/execute boundary.
module rv_control_unit #(
  parameter int OPCODE_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [2:0]              func3,
  input  logic [6:0]              func7,
  input  logic [19:0]             immidiate_data,
  output logic [3:0]              alu_op,
  output logic                    reg_wen,
  output logic                    reg_flag,
  output logic [31:0]             load_data
);

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE = OPCODE_WIDTH'(7'b0110011);
  localparam logic [OPCODE_WIDTH-1:0] OP_ITYPE = OPCODE_WIDTH'(7'b0010011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = OPCODE_WIDTH'(7'b0000011);
  localparam logic [OPCODE_WIDTH-1:0] OP_LUI   = OPCODE_WIDTH'(7'b0110111);

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001,
    ALU_NOP  = 4'b1111
  } alu_op_e;

  alu_op_e     funcOp;
  logic        funcLegal;
  logic [31:0] immSext;

  logic [3:0]  aluOp_d, aluOp_q;
  logic        regWen_d, regWen_q;
  logic        regFlag_d, regFlag_q;
  logic [31:0] loadData_d, loadData_q;

  assign immSext = {{12{immidiate_data[19]}}, immidiate_data};

  // Shared R/I func decode. For I-type, func7 is immediate bits and only
  // matters where it encodes a shift variant (func3 001/101).
  always_comb begin
    funcOp    = ALU_NOP;
    funcLegal = 1'b0;
    unique case (func3)
      3'b000: begin
        if (opcode == OP_ITYPE || func7 == F7_BASE) begin
          funcOp = ALU_ADD; funcLegal = 1'b1;
        end else if (func7 == F7_ALT) begin
          funcOp = ALU_SUB; funcLegal = 1'b1;
        end
      end
      3'b001: begin
        funcOp = ALU_SLL; funcLegal = (func7 == F7_BASE);
      end
      3'b101: begin
        if (func7 == F7_BASE) begin
          funcOp = ALU_SRL; funcLegal = 1'b1;
        end else if (func7 == F7_ALT) begin
          funcOp = ALU_SRA; funcLegal = 1'b1;
        end
      end
      default: begin
        unique case (func3)
          3'b010:  funcOp = ALU_SLT;
          3'b011:  funcOp = ALU_SLTU;
          3'b100:  funcOp = ALU_XOR;
          3'b110:  funcOp = ALU_OR;
          default: funcOp = ALU_AND;
        endcase
        funcLegal = (opcode == OP_ITYPE) || (func7 == F7_BASE);
      end
    endcase
  end

  always_comb begin
    aluOp_d    = ALU_NOP;
    regWen_d   = 1'b0;
    regFlag_d  = 1'b0;
    loadData_d = 32'h0;
    if (opcode == OP_RTYPE && funcLegal) begin
      aluOp_d  = funcOp;
      regWen_d = 1'b1;
    end else if (opcode == OP_ITYPE && funcLegal) begin
      aluOp_d    = funcOp;
      regWen_d   = 1'b1;
      loadData_d = immSext;
    end else if (opcode == OP_LOAD) begin
      aluOp_d    = ALU_ADD;
      regWen_d   = 1'b1;
      regFlag_d  = 1'b1;
      loadData_d = immSext;
    end else if (opcode == OP_LUI) begin
      aluOp_d    = ALU_NOP;
      regWen_d   = 1'b1;
      regFlag_d  = 1'b1;
      loadData_d = {immidiate_data, 12'h000};
    end
  end

  // Reset clears every output so no write enable leaks from a discarded decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aluOp_q    <= 4'b0000;
      regWen_q   <= 1'b0;
      regFlag_q  <= 1'b0;
      loadData_q <= 32'h0;
    end else begin
      aluOp_q    <= aluOp_d;
      regWen_q   <= regWen_d;
      regFlag_q  <= regFlag_d;
      loadData_q <= loadData_d;
    end
  end

  assign alu_op    = aluOp_q;
  assign reg_wen   = regWen_q;
  assign reg_flag  = regFlag_q;
  assign load_data = loadData_q;

endmodule

// File: tb/tb_rv_control_unit.sv
// Directed self-checking bench for rv_control_unit with hand-computed vectors.
module tb_rv_control_unit;

  logic        clk;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [19:0] immidiate_data;
  logic [3:0]  alu_op;
  logic        reg_wen;
  logic        reg_flag;
  logic [31:0] load_data;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] LU = 7'b0110111;

  rv_control_unit #(.OPCODE_WIDTH(7)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .func3(func3),
    .func7(func7),
    .immidiate_data(immidiate_data),
    .alu_op(alu_op),
    .reg_wen(reg_wen),
    .reg_flag(reg_flag),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expectAll(input string tag, input logic [3:0] expOp,
                           input logic expWen, input logic expFlag,
                           input logic [31:0] expData);
    checkOutput({tag, ".alu_op"},    {28'h0, alu_op},   {28'h0, expOp});
    checkOutput({tag, ".reg_wen"},   {31'h0, reg_wen},  {31'h0, expWen});
    checkOutput({tag, ".reg_flag"},  {31'h0, reg_flag}, {31'h0, expFlag});
    checkOutput({tag, ".load_data"}, load_data,         expData);
  endtask

  // Drive on the falling edge, then sample 1ns after the capturing rising edge.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic [19:0] imm);
    @(negedge clk);
    opcode = op; func3 = f3; func7 = f7; immidiate_data = imm;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    opcode = R; func3 = 3'b000; func7 = 7'b0100000; immidiate_data = 20'h0;
    #1 rst_n = 1'b0;
    #1 expectAll("reset_async", 4'b0000, 1'b0, 1'b0, 32'h0);

    // Reset held across an edge with a legal instruction present.
    @(posedge clk); #1;
    expectAll("reset_hold", 4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk) rst_n = 1'b1;

    applyStimulus(R, 3'b000, 7'b0000000, 20'h0);
    expectAll("r_add", 4'b0000, 1'b1, 1'b0, 32'h0);
    applyStimulus(R, 3'b000, 7'b0100000, 20'h12345);
    expectAll("r_sub", 4'b0001, 1'b1, 1'b0, 32'h0);
    applyStimulus(R, 3'b100, 7'b0000000, 20'h0);
    expectAll("r_xor", 4'b0101, 1'b1, 1'b0, 32'h0);
    applyStimulus(R, 3'b101, 7'b0100000, 20'h0);
    expectAll("r_sra", 4'b0111, 1'b1, 1'b0, 32'h0);
    applyStimulus(R, 3'b111, 7'b0000000, 20'h0);
    expectAll("r_and", 4'b1001, 1'b1, 1'b0, 32'h0);
    applyStimulus(R, 3'b111, 7'b0100000, 20'h0);
    expectAll("r_and_alt_illegal", 4'b1111, 1'b0, 1'b0, 32'h0);
    applyStimulus(R, 3'b000, 7'b0000001, 20'h0);
    expectAll("r_f7_illegal", 4'b1111, 1'b0, 1'b0, 32'h0);

    applyStimulus(LD, 3'b111, 7'b1111111, 20'h0AAAA);
    expectAll("load_pos", 4'b0000, 1'b1, 1'b1, 32'h0000AAAA);
    applyStimulus(LD, 3'b010, 7'b0000000, 20'h8000F);
    expectAll("load_neg", 4'b0000, 1'b1, 1'b1, 32'hFFF8000F);
    applyStimulus(LU, 3'b000, 7'b0100000, 20'h12345);
    expectAll("lui", 4'b1111, 1'b1, 1'b1, 32'h12345000);

    applyStimulus(I, 3'b101, 7'b0100000, 20'h00405);
    expectAll("i_sra", 4'b0111, 1'b1, 1'b0, 32'h00000405);
    applyStimulus(I, 3'b000, 7'b0100000, 20'hFFFFF);
    expectAll("i_add_f7ign", 4'b0000, 1'b1, 1'b0, 32'hFFFFFFFF);
    applyStimulus(I, 3'b010, 7'b1111111, 20'h00FFF);
    expectAll("i_slt", 4'b0011, 1'b1, 1'b0, 32'h00000FFF);
    applyStimulus(I, 3'b001, 7'b0100000, 20'h00001);
    expectAll("i_sll_illegal", 4'b1111, 1'b0, 1'b0, 32'h0);
    applyStimulus(I, 3'b110, 7'b0000000, 20'h80000);
    expectAll("i_or", 4'b1000, 1'b1, 1'b0, 32'hFFF80000);
    applyStimulus(7'b1111111, 3'b000, 7'b0000000, 20'h12345);
    expectAll("bad_opcode", 4'b1111, 1'b0, 1'b0, 32'h0);

    // Mid-cycle input change must not reach outputs before the next edge.
    applyStimulus(R, 3'b011, 7'b0000000, 20'h0);
    expectAll("r_sltu", 4'b0100, 1'b1, 1'b0, 32'h0);
    #2 opcode = LU; immidiate_data = 20'hABCDE;
    #1 expectAll("latency_hold", 4'b0100, 1'b1, 1'b0, 32'h0);
    @(posedge clk); #1;
    expectAll("latency_update", 4'b1111, 1'b1, 1'b1, 32'hABCDE000);

    // Reset asserted mid-stream clears outputs immediately.
    applyStimulus(LD, 3'b000, 7'b0000000, 20'h00123);
    expectAll("pre_reset_load", 4'b0000, 1'b1, 1'b1, 32'h00000123);
    #2 rst_n = 1'b0;
    #1 expectAll("midstream_reset", 4'b0000, 1'b0, 1'b0, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    expectAll("post_reset_first", 4'b0000, 1'b1, 1'b1, 32'h00000123);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
